satatx_framer: RTL
==================

Name: satatx_framer

Overview:
- Transmit link-layer framer that sits directly downstream of the TX scrambler.
- Takes scrambled 32-bit frame dwords over AXI-stream and produces the continuous dword stream for the PHY encoder.
- Wraps each frame with SOF/EOF primitives and fills stalls with HOLD or HOLDA.
- Emits WTRM after EOF until the receiver reports status, and SYNC when idle.

Parameters:
- ALIGN_INTERVAL, 256: number of output dwords between ALIGN pairs. Used only with SATATX_ALIGN_EN; legal range 4..65535.
- OPT_LOWPOWER, 1: when set, S_AXIS_TDATA is not propagated in non-data states; M_AXIS_TDATA carries only primitive constants.

Ports:
- S_AXI_ACLK  in  1  clock.
- i_reset  in  1  synchronous active-high reset.
- S_AXIS_TVALID  in  1  scrambled frame dword valid.
- S_AXIS_TREADY  out  1  framer accepts dword.
- S_AXIS_TDATA  in  32  scrambled dword (CRC already included upstream).
- S_AXIS_TLAST  in  1  last dword of frame.
- i_rx_hold  in  1  peer is sending HOLD; answer with HOLDA.
- i_rx_done  in  1  peer returned R_OK or R_ERR; ends WTRM.
- M_AXIS_TVALID  out  1  output dword valid.
- M_AXIS_TREADY  in  1  PHY consumes dword.
- M_AXIS_TDATA  out  32  dword to 8b/10b encoder.
- M_AXIS_TCHAR  out  1  1 = primitive (byte 0 is K28.5 or K28.3), 0 = data.
- o_busy  out  1  high from SOF emission through the last WTRM.

Behaviour:
- Clock and reset: one clock, S_AXI_ACLK. Reset i_reset is synchronous and active-high.
- Primitive constants (byte 0 first):
  - SYNC=32'hB5B5957C, SOF=32'h3737B57C, EOF=32'hD5D5B57C
  - HOLD=32'hD5D5AA7C, HOLDA=32'h9595AA7C, WTRM=32'h5858B57C
  - ALIGN=32'h7B4A4ABC
  - TCHAR=1 for every primitive.
- Output register advance: the output register updates only when !M_AXIS_TVALID || M_AXIS_TREADY (the "slot"). Otherwise TDATA/TCHAR hold stable.
- Reset values: M_AXIS_TVALID=0, TDATA=SYNC, TCHAR=1, o_busy=0, state=IDLE, ALIGN counter=0.
  - The first cycle after reset releases sets TVALID=1.
  - TVALID then stays 1 until the next reset: the stream is continuous.
- States: IDLE, DATA, EOF, WTRM.
  - IDLE: emit SYNC. If S_AXIS_TVALID on a slot, emit SOF and go to DATA. No dword is consumed.
  - DATA, i_rx_hold=1: emit HOLDA. No accept.
  - DATA, i_rx_hold=0 and S_AXIS_TVALID=1: accept the dword and emit it with TCHAR=0. If TLAST, go to EOF.
  - DATA, i_rx_hold=0 and S_AXIS_TVALID=0: emit HOLD.
  - EOF: emit EOF, go to WTRM.
  - WTRM: emit WTRM on each slot. When i_rx_done is sampled high on a slot, emit SYNC instead and go to IDLE.
- S_AXIS_TREADY = (state==DATA) && !i_rx_hold && (!M_AXIS_TVALID || M_AXIS_TREADY). It is combinational and never high in IDLE, EOF or WTRM.
- Latency: an accepted dword appears on M_AXIS_TDATA the cycle after the handshake.
- Priority with ALIGN enabled: ALIGN > HOLDA > data/HOLD.
- Single-dword frame: output sequence is SOF, D0, EOF, WTRM...
- i_rx_done high outside WTRM is ignored.
- i_rx_hold outside DATA is ignored.
- Reset mid-frame: the frame is abandoned and the next output is SYNC. Upstream is responsible for discarding the rest of the frame.
- o_busy = (state != IDLE), registered with the state.

Optional Feature:
- Macro: SATATX_ALIGN_EN.
- Defined:
  - A 16-bit counter increments on every output slot.
  - When it reaches ALIGN_INTERVAL-2, the next two slots emit ALIGN, ALIGN, and the counter wraps to 0.
  - During the ALIGN pair, the FSM state is frozen and S_AXIS_TREADY=0.
  - An ALIGN pair may split SOF/data/EOF/WTRM at any point.
- Not defined: no counter is built, ALIGN is never emitted, and the priority rule reduces to HOLDA > data/HOLD.

Test Plan:
- Reset release with M_AXIS_TREADY=1 and no input -> TVALID=1 with a continuous SYNC stream; TCHAR=1; S_AXIS_TREADY=0; o_busy=0.
- 3-dword frame (11111111, 22222222, 33333333 with TLAST), TREADY=1, then i_rx_done pulse 4 cycles after EOF -> output SOF, 11111111, 22222222, 33333333, EOF, WTRM×n, SYNC. TCHAR pattern is 1,0,0,0,1,1..,1.
- Upstream gap of 2 cycles mid-frame -> two HOLD dwords between data words; no data lost or duplicated.
- i_rx_hold high for 3 cycles mid-frame -> three HOLDA dwords; S_AXIS_TREADY=0 throughout; data resumes in order.
- M_AXIS_TREADY low for 5 cycles while data is pending -> TDATA/TCHAR stable; no input accepted. Then one transfer per cycle.
- With SATATX_ALIGN_EN and ALIGN_INTERVAL=8, a long frame -> an ALIGN,ALIGN pair every 8 output dwords; frame data is intact. Without the macro, the same stimulus produces no ALIGN.

Source files
------------

// File: rtl/satatx_framer.sv
// SATA TX link-layer framer: wraps scrambled frame dwords in SOF/EOF,
// fills stalls with HOLD/HOLDA, sends WTRM until status, SYNC when idle.
//
// Ports:
//   S_AXI_ACLK      clock
//   i_reset         synchronous active-high reset
//   S_AXIS_TVALID   scrambled frame dword valid
//   S_AXIS_TREADY   framer accepts the dword this cycle
//   S_AXIS_TDATA    scrambled dword (CRC already appended upstream)
//   S_AXIS_TLAST    last dword of the frame
//   i_rx_hold       peer sends HOLD, answer with HOLDA
//   i_rx_done       peer returned R_OK/R_ERR, ends WTRM
//   M_AXIS_TVALID   output dword valid (continuous after reset)
//   M_AXIS_TREADY   PHY consumes the dword
//   M_AXIS_TDATA    dword towards the 8b/10b encoder
//   M_AXIS_TCHAR    1 = primitive, 0 = data
//   o_busy          high from SOF emission through the last WTRM
//
// Parameters:
//   ALIGN_INTERVAL  output dwords per ALIGN period (4..65535)
//   OPT_LOWPOWER    gate S_AXIS_TDATA off outside accepted data beats
//
// Build option:
//   SATATX_ALIGN_EN defined -> an ALIGN pair is inserted every
//   ALIGN_INTERVAL output dwords, freezing the frame state meanwhile.

module satatx_framer #(
    parameter int ALIGN_INTERVAL = 256,
    parameter bit OPT_LOWPOWER   = 1'b1
) (
    input  logic        S_AXI_ACLK,
    input  logic        i_reset,
    input  logic        S_AXIS_TVALID,
    output logic        S_AXIS_TREADY,
    input  logic [31:0] S_AXIS_TDATA,
    input  logic        S_AXIS_TLAST,
    input  logic        i_rx_hold,
    input  logic        i_rx_done,
    output logic        M_AXIS_TVALID,
    input  logic        M_AXIS_TREADY,
    output logic [31:0] M_AXIS_TDATA,
    output logic        M_AXIS_TCHAR,
    output logic        o_busy
);

    localparam logic [31:0] P_SYNC  = 32'hB5B5957C;
    localparam logic [31:0] P_SOF   = 32'h3737B57C;
    localparam logic [31:0] P_EOF   = 32'hD5D5B57C;
    localparam logic [31:0] P_HOLD  = 32'hD5D5AA7C;
    localparam logic [31:0] P_HOLDA = 32'h9595AA7C;
    localparam logic [31:0] P_WTRM  = 32'h5858B57C;
    localparam logic [31:0] P_ALIGN = 32'h7B4A4ABC;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_EOF,
        S_WTRM
    } state_t;

    state_t      r_state;
    logic        r_tvalid;
    logic [31:0] r_tdata;
    logic        r_tchar;
    logic        r_busy;

    logic        w_slot;
    logic        w_align;
    logic        w_ready;
    logic        w_accept;
    logic [31:0] w_din;

    // The output register may only advance when it is empty or
    // being consumed; everything else keys off this.
    assign w_slot = !r_tvalid || M_AXIS_TREADY;

`ifdef SATATX_ALIGN_EN
    localparam logic [15:0] AL_FIRST = 16'(ALIGN_INTERVAL - 2);
    localparam logic [15:0] AL_LAST  = 16'(ALIGN_INTERVAL - 1);

    logic [15:0] r_acnt;

    // Counter runs over every slot; its last two positions of each
    // period are the ALIGN pair, after which it wraps to zero.
    assign w_align = (r_acnt >= AL_FIRST);

    always_ff @(posedge S_AXI_ACLK) begin
        if (i_reset) begin
            r_acnt <= '0;
        end else if (w_slot) begin
            if (r_acnt == AL_LAST)
                r_acnt <= '0;
            else
                r_acnt <= r_acnt + 16'd1;
        end
    end
`else
    logic w_unused_cfg;

    assign w_align      = 1'b0;
    assign w_unused_cfg = ALIGN_INTERVAL[0];
`endif

    // Ready is withheld while the peer holds us off and while an
    // ALIGN pair owns the slot.
    assign w_ready = (r_state == S_DATA) && !i_rx_hold
                  && w_slot && !w_align;

    assign w_accept = w_ready && S_AXIS_TVALID;

    assign w_din = (OPT_LOWPOWER && !w_accept) ? '0 : S_AXIS_TDATA;

    assign S_AXIS_TREADY = w_ready;
    assign M_AXIS_TVALID = r_tvalid;
    assign M_AXIS_TDATA  = r_tdata;
    assign M_AXIS_TCHAR  = r_tchar;
    assign o_busy        = r_busy;

    always_ff @(posedge S_AXI_ACLK) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_tvalid <= 1'b0;
            r_tdata  <= P_SYNC;
            r_tchar  <= 1'b1;
            r_busy   <= 1'b0;
        end else if (w_slot) begin
            r_tvalid <= 1'b1;
            r_tchar  <= 1'b1;
            if (w_align) begin
                r_tdata <= P_ALIGN;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (S_AXIS_TVALID) begin
                            r_tdata <= P_SOF;
                            r_state <= S_DATA;
                            r_busy  <= 1'b1;
                        end else begin
                            r_tdata <= P_SYNC;
                        end
                    end
                    S_DATA: begin
                        if (i_rx_hold) begin
                            r_tdata <= P_HOLDA;
                        end else if (S_AXIS_TVALID) begin
                            r_tdata <= w_din;
                            r_tchar <= 1'b0;
                            if (S_AXIS_TLAST)
                                r_state <= S_EOF;
                        end else begin
                            r_tdata <= P_HOLD;
                        end
                    end
                    S_EOF: begin
                        r_tdata <= P_EOF;
                        r_state <= S_WTRM;
                    end
                    S_WTRM: begin
                        if (i_rx_done) begin
                            r_tdata <= P_SYNC;
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_tdata <= P_WTRM;
                        end
                    end
                endcase
            end
        end
    end

endmodule
